// File: rtl/cpu_pkg.sv
// Shared types and widths for the data-memory arbiter and its requesters.
package cpu_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    typedef struct packed {
        logic [LANES-1:0]  we;
        logic [LANES-1:0]  re;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/datamem_arbiter_if.sv
// Bundles the CPU, external-port and datamem signals seen by the arbiter.
interface datamem_arbiter_if;
    import cpu_pkg::*;

    logic              cpu_req;
    logic [LANES-1:0]  cpu_we;
    logic [LANES-1:0]  cpu_re;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_lock;
    logic [LANES-1:0]  ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [LANES-1:0]  mem_we;
    logic [LANES-1:0]  mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_re, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_lock, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_addr, mem_we, mem_re, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_re, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_lock, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_addr, mem_we, mem_re, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with clear; sat_o flags the count sitting at MAX.
module arb_wait_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned CNT_W = (MAX > 1) ? $clog2(MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] base;

    // A clear and an increment in the same cycle restart the count at one.
    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base != CNT_MAX)) begin
            cnt_d = base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/datamem_arbiter.sv
// Shares the data memory between the CPU MEM stage (priority) and an
// external loader port with starvation protection and locked bursts.
module datamem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic clk,
    input  logic reset,
    datamem_arbiter_if.slave bus
);

    localparam bit BURST_EN = (MAX_BURST > 32'd1);

    owner_e   state_q;
    owner_e   state_d;
    logic     ext_grant;
    logic     cpu_grant;
    logic     wait_sat;
    logic     burst_sat;
    logic     ext_rd;
    logic     ext_rvalid_q;
    logic [DATA_W-1:0] ext_rdata_q;
    mem_req_t cpu_r;
    mem_req_t ext_r;
    mem_req_t mem_r;

    always_comb begin
        cpu_r.we    = bus.cpu_we;
        cpu_r.re    = bus.cpu_re;
        cpu_r.addr  = bus.cpu_addr;
        cpu_r.wdata = bus.cpu_wdata;
        ext_r.we    = bus.ext_we;
        ext_r.re    = (bus.ext_we == '0) ? '1 : '0;
        ext_r.addr  = bus.ext_addr;
        ext_r.wdata = bus.ext_wdata;
    end

    // Grant decision, ownership transitions and memory-side mux.
    always_comb begin
        state_d   = state_q;
        ext_grant = 1'b0;
        cpu_grant = 1'b0;
        mem_r     = '0;
        unique case (state_q)
            OWN_CPU: begin
                if (bus.ext_req && (!bus.cpu_req || wait_sat)) begin
                    ext_grant = 1'b1;
                end else begin
                    cpu_grant = bus.cpu_req;
                end
                if (ext_grant && bus.ext_lock && BURST_EN) begin
                    state_d = OWN_EXT;
                end
            end
            OWN_EXT: begin
                ext_grant = bus.ext_req;
                if (!bus.ext_req || !bus.ext_lock || burst_sat) begin
                    state_d = OWN_CPU;
                end
            end
            default: state_d = OWN_CPU;
        endcase
        if (reset) begin
            ext_grant = 1'b0;
        end
        if (ext_grant) begin
            mem_r = ext_r;
        end else if (cpu_grant) begin
            mem_r = cpu_r;
        end
        if (reset) begin
            mem_r.we = '0;
        end
    end

    arb_wait_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (bus.ext_req && !ext_grant),
        .clr_i (ext_grant || !bus.ext_req),
        .sat_o (wait_sat)
    );

    // Saturates on the last permitted cycle of a burst; the entry grant counts.
    arb_wait_counter #(.MAX(MAX_BURST - 1)) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (ext_grant),
        .clr_i (state_q == OWN_CPU),
        .sat_o (burst_sat)
    );

    assign ext_rd = ext_grant && (bus.ext_we == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= OWN_CPU;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ext_rvalid_q <= ext_rd;
            if (ext_rd) begin
                ext_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr   = mem_r.addr;
    assign bus.mem_we     = mem_r.we;
    assign bus.mem_re     = mem_r.re;
    assign bus.mem_wdata  = mem_r.wdata;
    assign bus.cpu_stall  = bus.cpu_req && !cpu_grant;
    assign bus.cpu_rdata  = cpu_grant ? bus.mem_rdata : '0;
    assign bus.ext_gnt    = ext_grant;
    assign bus.ext_rvalid = ext_rvalid_q;
    assign bus.ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Randomized and directed bench for datamem_arbiter with a behavioural model.
module tb_datamem_arbiter;

    localparam int unsigned MAX_WAIT  = 4;
    localparam int unsigned MAX_BURST = 8;

    logic clk;
    logic reset;
    datamem_arbiter_if bus();

    datamem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Memory array driven by the DUT's mem_* port.
    logic [7:0]  mem [128];
    logic        mem_init = 1'b0;
    logic [31:0] mem_rd;

    always_comb begin
        mem_rd = '0;
        for (int i = 0; i < 4; i++)
            if (bus.mem_re[i]) mem_rd[31-8*i -: 8] = mem[7'(bus.mem_addr + 7'(i))];
    end
    assign bus.mem_rdata = mem_rd;

    always @(posedge clk) begin
        if (reset && !mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_byte(i);
            mem_init <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i]) mem[7'(bus.mem_addr + 7'(i))] <= bus.mem_wdata[31-8*i -: 8];
        end
    end

    // Behavioural model: expected memory contents plus arbitration bookkeeping.
    logic [7:0]  gold [128];
    bit          m_valid = 1'b0;
    bit          gold_init = 1'b0;
    int          m_starve, m_used;
    bit          m_owner, m_rv;
    logic [31:0] m_rd;

    bit          n_ok;
    int          n_starve, n_used;
    bit          n_owner, n_rv;
    logic [31:0] n_rd;
    logic [3:0]  n_we;
    logic [6:0]  n_waddr;
    logic [31:0] n_wdata;

    bit          c_gext, c_gcpu;
    logic [3:0]  c_we, c_re;
    logic [6:0]  c_addr;
    logic [31:0] c_wd;

    function automatic logic [31:0] gold_word(input logic [6:0] a, input logic [3:0] re);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (re[i]) w[31-8*i -: 8] = gold[7'(a + 7'(i))];
        return w;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            if (!gold_init) begin
                for (int i = 0; i < 128; i++) gold[i] <= init_byte(i);
                gold_init <= 1'b1;
            end
            m_valid  <= 1'b1;
            m_starve <= 0;
            m_used   <= 0;
            m_owner  <= 1'b0;
            m_rv     <= 1'b0;
            m_rd     <= '0;
        end else if (m_valid && n_ok) begin
            m_starve <= n_starve;
            m_used   <= n_used;
            m_owner  <= n_owner;
            m_rv     <= n_rv;
            m_rd     <= n_rd;
            for (int i = 0; i < 4; i++)
                if (n_we[i]) gold[7'(n_waddr + 7'(i))] <= n_wdata[31-8*i -: 8];
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        n_ok = 1'b0;
        if (m_valid) begin
            if (m_owner) begin
                c_gext = bus.ext_req;
                c_gcpu = 1'b0;
            end else begin
                c_gext = bus.ext_req && (!bus.cpu_req || m_starve >= MAX_WAIT);
                c_gcpu = bus.cpu_req && !c_gext;
            end
            chk("ext_rvalid", 32'(bus.ext_rvalid), 32'(m_rv));
            chk("ext_rdata", bus.ext_rdata, m_rd);
            if (reset) begin
                chk("mem_we_in_reset", 32'(bus.mem_we), 32'h0);
                chk("ext_gnt_in_reset", 32'(bus.ext_gnt), 32'h0);
            end else begin
                c_we = '0; c_re = '0; c_addr = '0; c_wd = '0;
                if (c_gext) begin
                    c_we = bus.ext_we; c_re = (bus.ext_we == 0) ? 4'hF : 4'h0;
                    c_addr = bus.ext_addr; c_wd = bus.ext_wdata;
                end else if (c_gcpu) begin
                    c_we = bus.cpu_we; c_re = bus.cpu_re;
                    c_addr = bus.cpu_addr; c_wd = bus.cpu_wdata;
                end
                chk("ext_gnt", 32'(bus.ext_gnt), 32'(c_gext));
                chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !c_gcpu));
                chk("cpu_rdata", bus.cpu_rdata, c_gcpu ? gold_word(bus.cpu_addr, bus.cpu_re) : 32'h0);
                chk("mem_we", 32'(bus.mem_we), 32'(c_we));
                chk("mem_re", 32'(bus.mem_re), 32'(c_re));
                if (c_gext || c_gcpu) begin
                    chk("mem_addr", 32'(bus.mem_addr), 32'(c_addr));
                    chk("mem_wdata", bus.mem_wdata, c_wd);
                end
                n_we = c_we; n_waddr = c_addr; n_wdata = c_wd;
                n_starve = (bus.ext_req && !c_gext) ?
                           ((m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT) : 0;
                if (!m_owner) begin
                    n_owner = c_gext && bus.ext_lock && (MAX_BURST > 1);
                    n_used  = c_gext ? 1 : 0;
                end else begin
                    n_used  = m_used + (c_gext ? 1 : 0);
                    n_owner = bus.ext_req && bus.ext_lock && (n_used < MAX_BURST);
                end
                n_rv = c_gext && (bus.ext_we == 0);
                n_rd = n_rv ? gold_word(bus.ext_addr, 4'hF) : m_rd;
                n_ok = 1'b1;
            end
        end
    end

    task automatic set_cpu(input bit req, input logic [3:0] we, input logic [3:0] re,
                           input logic [6:0] addr, input logic [31:0] wd);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_re = re;
        bus.cpu_addr = addr; bus.cpu_wdata = wd;
    endtask

    task automatic set_ext(input bit req, input bit lock, input logic [3:0] we,
                           input logic [6:0] addr, input logic [31:0] wd);
        bus.ext_req = req; bus.ext_lock = lock; bus.ext_we = we;
        bus.ext_addr = addr; bus.ext_wdata = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_cpu(0, 0, 0, 0, 0);
        set_ext(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("lit_rst_rvalid", 32'(bus.ext_rvalid), 32'h0);
        chk("lit_rst_rdata", bus.ext_rdata, 32'h0);
        chk("lit_rst_gnt", 32'(bus.ext_gnt), 32'h0);
        next_cycle();

        // CPU alone owns memory
        set_cpu(1, 4'hF, 4'h0, 7'h10, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lit_idle_we", 32'(bus.mem_we), 32'hF);
            chk("lit_idle_stall", 32'(bus.cpu_stall), 32'h0);
            next_cycle();
        end
        set_cpu(1, 4'h0, 4'hF, 7'h10, 32'h0);
        @(negedge clk);
        chk("lit_idle_readback", bus.cpu_rdata, 32'hDEADBEEF);
        next_cycle();
        set_cpu(1, 4'hF, 4'h0, 7'h20, 32'h01020304);
        next_cycle();

        // Starvation: ext forced in on the fifth denied cycle
        set_cpu(1, 4'h0, 4'hF, 7'h10, 32'h0);
        set_ext(1, 0, 4'h0, 7'h20, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("lit_starve_gnt", 32'(bus.ext_gnt), 32'(k == 4));
            chk("lit_starve_stall", 32'(bus.cpu_stall), 32'(k == 4));
            if (k == 5) chk("lit_starve_rdata", bus.ext_rdata, 32'h01020304);
            next_cycle();
        end
        set_ext(0, 0, 0, 0, 0);
        next_cycle();

        // External read latency
        set_cpu(0, 0, 0, 0, 0);
        set_ext(1, 0, 4'h0, 7'h20, 32'h0);
        @(negedge clk);
        chk("lit_lat_gnt", 32'(bus.ext_gnt), 32'h1);
        chk("lit_lat_rvalid0", 32'(bus.ext_rvalid), 32'h0);
        next_cycle();
        set_ext(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_lat_rvalid1", 32'(bus.ext_rvalid), 32'h1);
        chk("lit_lat_rdata", bus.ext_rdata, 32'h01020304);
        next_cycle();
        @(negedge clk);
        chk("lit_lat_rvalid2", 32'(bus.ext_rvalid), 32'h0);
        next_cycle();

        // Locked burst limited to MAX_BURST cycles
        set_cpu(1, 4'h0, 4'hF, 7'h10, 32'h0);
        set_ext(1, 1, 4'h0, 7'h30, 32'h0);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk("lit_burst_gnt", 32'(bus.ext_gnt), 32'(k >= 4 && k <= 11));
            if (k == 12) chk("lit_burst_stall", 32'(bus.cpu_stall), 32'h0);
            next_cycle();
        end
        set_ext(0, 0, 0, 0, 0);
        next_cycle();

        // Reset in the third cycle of a burst
        set_cpu(0, 0, 0, 0, 0);
        set_ext(1, 1, 4'h0, 7'h20, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("lit_rb_gnt", 32'(bus.ext_gnt), 32'h1);
            next_cycle();
        end
        reset = 1'b1;
        set_ext(1, 1, 4'hF, 7'h20, 32'h55555555);
        @(negedge clk);
        chk("lit_rb_we", 32'(bus.mem_we), 32'h0);
        chk("lit_rb_gnt_rst", 32'(bus.ext_gnt), 32'h0);
        next_cycle();
        reset = 1'b0;
        set_cpu(1, 4'h0, 4'hF, 7'h20, 32'h0);
        @(negedge clk);
        chk("lit_rb_rvalid", 32'(bus.ext_rvalid), 32'h0);
        chk("lit_rb_gnt_after", 32'(bus.ext_gnt), 32'h0);
        chk("lit_rb_stall", 32'(bus.cpu_stall), 32'h0);
        chk("lit_rb_rdata", bus.cpu_rdata, 32'h01020304);
        next_cycle();

        // Address wrap handled by memory
        set_ext(0, 0, 0, 0, 0);
        set_cpu(1, 4'hF, 4'h0, 7'h7E, 32'hAABBCCDD);
        next_cycle();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_wrap_7e", 32'(mem[126]), 32'hAA);
        chk("lit_wrap_7f", 32'(mem[127]), 32'hBB);
        chk("lit_wrap_00", 32'(mem[0]), 32'hCC);
        chk("lit_wrap_01", 32'(mem[1]), 32'hDD);
        next_cycle();

        // Random traffic checked by the model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            set_cpu($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                    4'($urandom), 7'($urandom), $urandom);
            set_ext($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                    7'($urandom), $urandom);
            next_cycle();
        end
        reset = 1'b0;
        set_cpu(0, 0, 0, 0, 0);
        set_ext(0, 0, 0, 0, 0);
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single 128-byte data memory between two requesters: the CPU MEM stage (primary) and an external loader/debug port (secondary).
- The CPU has priority. The external port is protected against starvation by a wait counter and may hold the memory for a locked burst.
- Produces a stall to the pipeline whenever the CPU MEM-stage access is not granted in the current cycle.
- Sits between the ExMem stage and the datamem array.

Parameters:
- ADDR_W, 7, byte address width (128-byte memory).
- DATA_W, 32, word width; byte lanes = DATA_W/8 = 4.
- MAX_WAIT, 4, consecutive cycles the external port may be denied before it is forced a grant.
- MAX_BURST, 8, maximum cycles one locked external burst may hold the memory.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU MEM stage requests access (MemRead or MemWrite nonzero).
- cpu_we  in  4  CPU byte write enables; bit0 = byte at addr (bits 31:24).
- cpu_re  in  4  CPU byte read enables; same lane mapping as cpu_we.
- cpu_addr  in  7  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data; combinational from mem_rdata when granted.
- cpu_stall  out  1  freezes PC, IfId, IdEx and ExMem for this cycle.
- ext_req  in  1  external port request.
- ext_lock  in  1  external port requests to keep the grant next cycle (burst).
- ext_we  in  4  external byte write enables.
- ext_addr  in  7  external byte address.
- ext_wdata  in  32  external write data.
- ext_gnt  out  1  external access performed this cycle.
- ext_rvalid  out  1  registered; high the cycle after a granted external read.
- ext_rdata  out  32  registered read data, valid with ext_rvalid.
- mem_addr  out  7  address to datamem.
- mem_we  out  4  byte write enables to datamem (written on posedge).
- mem_re  out  4  byte read enables to datamem.
- mem_wdata  out  32  write data to datamem.
- mem_rdata  in  32  combinational read data from datamem.

Behaviour:
- FSM states are OWN_CPU and OWN_EXT. Reset state is OWN_CPU.
- Reset values: wait_cnt=0, burst_cnt=0, ext_rvalid=0, ext_rdata=0.
- Reset has priority over all other inputs; a burst in progress is abandoned with no partial write beyond the current cycle.
- While reset is asserted, mem_we=0 and ext_gnt=0. cpu_stall still follows the combinational rule below.
- Grant decision (combinational, per cycle):
  - In OWN_EXT with ext_req=1: grant EXT.
  - In OWN_CPU: grant EXT if ext_req and (!cpu_req or wait_cnt==MAX_WAIT); otherwise grant CPU if cpu_req.
  - Otherwise: no grant, and all mem_* enables are 0.
- Muxing:
  - Granted requester drives mem_addr, mem_we and mem_wdata.
  - Ext reads use mem_re=4'b1111 when ext_we==0.
  - Non-granted side sees no effect.
- cpu_stall = cpu_req & !cpu_grant.
- cpu_rdata = mem_rdata when cpu_grant, else 0.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when ext_req & !ext_grant.
  - Cleared on ext_grant or when ext_req=0.
- Transitions:
  - OWN_CPU -> OWN_EXT when ext_grant & ext_lock & MAX_BURST>1.
  - OWN_EXT -> OWN_CPU when ext_req=0, or ext_lock=0, or burst_cnt==MAX_BURST-1.
- burst_cnt:
  - Counts granted cycles in OWN_EXT.
  - Cleared on entry to OWN_EXT and in OWN_CPU.
  - The burst limit forces release even if ext_lock stays high.
  - The external port then competes again with wait_cnt=0.
- Ext read latency is exactly 1 cycle: ext_rvalid<=ext_grant&(ext_we==0), and ext_rdata<=mem_rdata in the same condition.
- Address wrap: lane offsets addr+1..addr+3 wrap mod 128. The arbiter passes the address unmodified; datamem performs the wrap.
- Simultaneous CPU and ext writes to the same address: only the granted write occurs. No merging.

Decomposition:
- Shared package cpu_pkg holds:
  - the owner_e enum (OWN_CPU, OWN_EXT);
  - the mem_req_t packed struct {we[3:0], re[3:0], addr[6:0], wdata[31:0]} used by both requester ports;
  - the constants ADDR_W and DATA_W.
- One sub-module, arb_wait_counter: the saturating starvation counter (inc, clr, sat output), reused for burst_cnt.

Test Plan:
- Idle: cpu_req=1, cpu_we=4'b1111, addr=0x10, wdata=0xDEADBEEF, ext_req=0 -> mem_we=1111, cpu_stall=0 every cycle; word at 0x10 reads back 0xDEADBEEF.
- Starvation: cpu_req held 1, ext_req=1 from cycle 0 with MAX_WAIT=4 -> ext_gnt first at cycle 4, cpu_stall=1 in that cycle only, wait_cnt returns to 0.
- Ext read latency: ext_req=1 read addr 0x20 containing 0x01020304, cpu_req=0 -> ext_gnt same cycle; ext_rvalid=1 and ext_rdata=0x01020304 exactly one cycle later.
- Burst limit: ext_lock=1, ext_req=1 for 12 cycles, cpu_req=1, MAX_BURST=8 -> ext owns 8 consecutive cycles, then CPU granted, cpu_stall low for at least 1 cycle.
- Reset mid-burst: assert reset in burst cycle 3 -> next cycle state OWN_CPU, ext_rvalid=0, no mem_we during reset, cpu granted once reset drops.
- Wrap: CPU word write at addr 0x7E with 0xAABBCCDD -> bytes 0x7E=AA, 0x7F=BB, 0x00=CC, 0x01=DD.
